counter_table_ctrl: RTL

Sequencing controller for the 256-entry × 3-bit saturating-counter table (the branch-history counter array). It owns the table's single address/write port and arbitrates it among three users: prediction lookups from fetch, training updates from branch resolution (read-modify-write with saturating ±1), and a full-table clear sweep after reset or flush. All table traffic goes through this block. Nothing else drives the table's Addr/Wen/Din.

---
 rtl/counter_table_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/counter_table_ctrl.sv
// counter_table_ctrl: owns the single port of the 256x3 saturating-counter table and
// arbitrates clear sweeps, training read-modify-writes and prediction lookups.
`default_nettype none

module counter_table_ctrl #(
  parameter logic [2:0] CLR_VAL      = 3'd3,
  parameter bit         CLR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pred_valid,
  input  logic [7:0] i_pred_addr,
  output logic       o_pred_ready,
  output logic       o_pred_rsp_valid,
  output logic [2:0] o_pred_rsp_cnt,
  output logic       o_pred_rsp_taken,
  input  logic       i_upd_valid,
  input  logic [7:0] i_upd_addr,
  input  logic       i_upd_taken,
  output logic       o_upd_ready,
  input  logic       i_flush_req,
  output logic       o_flush_busy,
  output logic [7:0] o_tbl_addr,
  output logic       o_tbl_wen,
  output logic [2:0] o_tbl_din,
  input  logic [2:0] i_tbl_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPD_WR = 2'd1,
    S_CLEAR  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_upd_addr;
  logic       r_upd_taken;
  logic [7:0] r_clr_idx;
  logic [7:0] w_clr_idx_nxt;
  logic       r_flush_pend;
  logic       w_flush_pend_nxt;
  logic       r_pred_rsp_valid;
  logic       w_upd_ready;
  logic       w_pred_ready;
  logic       w_flush_go;
  logic       w_wen;
  logic [7:0] w_addr;
  logic [2:0] w_din;
  logic [2:0] w_sat_inc;
  logic [2:0] w_sat_dec;

  assign w_flush_go   = (r_state == S_IDLE) && (i_flush_req || r_flush_pend);
  assign w_upd_ready  = (r_state == S_IDLE) && !i_flush_req && !r_flush_pend;
  assign w_pred_ready = w_upd_ready && !i_upd_valid;

  assign w_sat_inc = (i_tbl_dout == 3'd7) ? 3'd7 : i_tbl_dout + 3'd1;
  assign w_sat_dec = (i_tbl_dout == 3'd0) ? 3'd0 : i_tbl_dout - 3'd1;

  always_comb begin
    w_state_nxt      = r_state;
    w_clr_idx_nxt    = r_clr_idx;
    w_flush_pend_nxt = r_flush_pend;
    w_addr           = 8'd0;
    w_wen            = 1'b0;
    w_din            = 3'd0;
    case (r_state)
      S_IDLE: begin
        if (w_flush_go) begin
          w_state_nxt      = S_CLEAR;
          w_clr_idx_nxt    = 8'd0;
          w_flush_pend_nxt = 1'b0;
        end else if (i_upd_valid) begin
          w_state_nxt = S_UPD_WR;
          w_addr      = i_upd_addr;
        end else if (i_pred_valid) begin
          w_addr = i_pred_addr;
        end
      end
      S_UPD_WR: begin
        w_state_nxt = S_IDLE;
        w_addr      = r_upd_addr;
        w_wen       = 1'b1;
        w_din       = r_upd_taken ? w_sat_inc : w_sat_dec;
        if (i_flush_req) w_flush_pend_nxt = 1'b1;
      end
      S_CLEAR: begin
        w_addr        = r_clr_idx;
        w_wen         = 1'b1;
        w_din         = CLR_VAL;
        w_clr_idx_nxt = r_clr_idx + 8'd1;
        if (r_clr_idx == 8'd255) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= CLR_ON_RESET ? S_CLEAR : S_IDLE;
      r_upd_addr       <= 8'd0;
      r_upd_taken      <= 1'b0;
      r_clr_idx        <= 8'd0;
      r_flush_pend     <= 1'b0;
      r_pred_rsp_valid <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_clr_idx        <= w_clr_idx_nxt;
      r_flush_pend     <= w_flush_pend_nxt;
      r_pred_rsp_valid <= w_pred_ready && i_pred_valid;
      if (w_upd_ready && i_upd_valid) begin
        r_upd_addr  <= i_upd_addr;
        r_upd_taken <= i_upd_taken;
      end
    end
  end

  // Write enable is gated by reset so an aborted sweep or update never commits a write.
  assign o_tbl_wen        = w_wen && rst_n;
  assign o_tbl_addr       = w_addr;
  assign o_tbl_din        = w_din;
  assign o_upd_ready      = w_upd_ready;
  assign o_pred_ready     = w_pred_ready;
  assign o_flush_busy     = (r_state == S_CLEAR) || r_flush_pend;
  assign o_pred_rsp_valid = r_pred_rsp_valid;
  assign o_pred_rsp_cnt   = r_pred_rsp_valid ? i_tbl_dout : 3'd0;
  assign o_pred_rsp_taken = r_pred_rsp_valid && i_tbl_dout[2];

endmodule

`default_nettype wire
